// File: rtl/resp_misr_pkg.sv
// Shared types and default constants for the response MISR compactor.
package resp_misr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          SIG_W_DEF = 16;
   localparam int          CNT_W_DEF = 16;
   localparam logic [15:0] POLY_DEF  = 16'h1021;

endpackage

// File: rtl/misr_step.sv
// One combinational MISR step: Galois-form shift with polynomial feedback, then XOR in the response word.
module misr_step #(
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
   input  logic [SIG_W-1:0] sig,
   input  logic [SIG_W-1:0] r,
   output logic [SIG_W-1:0] sig_next
);

   logic [SIG_W-1:0] shifted;
   logic [SIG_W-1:0] feedback;

   always_comb begin
      shifted  = {sig[SIG_W-2:0], 1'b0};
      feedback = sig[SIG_W-1] ? POLY : '0;
      sig_next = shifted ^ feedback ^ r;
   end

endmodule

// File: rtl/resp_misr_compactor.sv
// Compacts a fixed-length session of 4-bit gate responses into a MISR signature with a ready/valid handoff.
//
// state | meaning
// IDLE  | waiting for start; signature/vec_count keep the last session's result
// RUN   | accepting response vectors until vec_count reaches the latched num_vec
// DONE  | signature presented on sig_valid, held until sig_ready
module resp_misr_compactor
   import resp_misr_pkg::*;
#(
   parameter int               SIG_W = SIG_W_DEF,
   parameter int               CNT_W = CNT_W_DEF,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic [SIG_W-1:0] seed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             u0,
   input  logic             u1,
   input  logic             w0,
   input  logic             w1,
   output logic             sig_valid,
   input  logic             sig_ready,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count,
   output logic             busy
);

   state_t           state, state_nx;
   logic [SIG_W-1:0] sig, sig_nx, sig_step, resp;
   logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
   logic [CNT_W-1:0] num_lat, num_nx;

   assign resp    = {{(SIG_W-4){1'b0}}, w1, w0, u1, u0};
   assign cnt_inc = cnt + 1'b1;

   misr_step #(
      .SIG_W (SIG_W),
      .POLY  (POLY)
   ) u_step (
      .sig      (sig),
      .r        (resp),
      .sig_next (sig_step)
   );

   always_comb begin
      state_nx = state;
      sig_nx   = sig;
      cnt_nx   = cnt;
      num_nx   = num_lat;
      case (state)
         IDLE: begin
            if (start) begin
               sig_nx   = seed;
               cnt_nx   = '0;
               num_nx   = num_vec;
               state_nx = (num_vec == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (in_valid) begin
               sig_nx = sig_step;
               cnt_nx = cnt_inc;
               if (cnt_inc == num_lat) state_nx = DONE;
            end
         end
         DONE: begin
            // start coinciding with sig_ready only closes the session
            if (sig_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sig     <= '0;
         cnt     <= '0;
         num_lat <= '0;
      end else begin
         state   <= state_nx;
         sig     <= sig_nx;
         cnt     <= cnt_nx;
         num_lat <= num_nx;
      end
   end

   assign in_ready  = (state == RUN);
   assign sig_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign signature = sig;
   assign vec_count = cnt;

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Directed bench for resp_misr_compactor with hand-computed MISR signatures.
module tb_resp_misr_compactor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] num_vec;
   logic [15:0] seed;
   logic        in_valid;
   logic        in_ready;
   logic        u0, u1, w0, w1;
   logic        sig_valid;
   logic        sig_ready;
   logic [15:0] signature;
   logic [15:0] vec_count;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   resp_misr_compactor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_vec   (num_vec),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .u0        (u0),
      .u1        (u1),
      .w0        (w0),
      .w1        (w1),
      .sig_valid (sig_valid),
      .sig_ready (sig_ready),
      .signature (signature),
      .vec_count (vec_count),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_r(input logic [3:0] r);
      {w1, w0, u1, u0} = r;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num_vec = '0; seed = '0;
      in_valid = 1'b0; sig_ready = 1'b0; set_r(4'h0);
      step(); step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_sig_valid", sig_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sig", signature, 0);
      chk("rst_cnt", vec_count, 0);
      rst_n = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      // seed 0, two vectors 5 then F
      seed = 16'h0000; num_vec = 16'd2; start = 1'b1;
      step();
      start = 1'b0; seed = 16'hFFFF; num_vec = 16'd9;
      chk("s1_in_ready", in_ready, 1);
      chk("s1_busy", busy, 1);
      chk("s1_seed_loaded", signature, 16'h0000);
      chk("s1_cnt0", vec_count, 0);
      in_valid = 1'b1; set_r(4'h5);
      step();
      chk("s1_sig_v1", signature, 16'h0005);
      chk("s1_cnt_v1", vec_count, 1);
      chk("s1_not_done", sig_valid, 0);
      set_r(4'hF);
      step();
      in_valid = 1'b0;
      chk("s1_sig_valid", sig_valid, 1);
      chk("s1_sig_v2", signature, 16'h0005);
      chk("s1_cnt_v2", vec_count, 2);
      chk("s1_in_ready_done", in_ready, 0);
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;
      chk("s1_idle_busy", busy, 0);
      chk("s1_idle_sig_valid", sig_valid, 0);
      chk("s1_idle_sig_hold", signature, 16'h0005);
      chk("s1_idle_cnt_hold", vec_count, 2);

      // feedback: seed 8000, r=0 -> POLY
      seed = 16'h8000; num_vec = 16'd1; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; set_r(4'h0);
      step();
      in_valid = 1'b0;
      chk("s2_sig_valid", sig_valid, 1);
      chk("s2_sig", signature, 16'h1021);
      chk("s2_cnt", vec_count, 1);
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;

      // num_vec = 0 goes straight to DONE
      seed = 16'hBEEF; num_vec = 16'd0; start = 1'b1;
      step();
      start = 1'b0;
      chk("s3_in_ready", in_ready, 0);
      chk("s3_sig_valid", sig_valid, 1);
      chk("s3_sig", signature, 16'hBEEF);
      chk("s3_cnt", vec_count, 0);
      in_valid = 1'b1; set_r(4'h7);
      step();
      in_valid = 1'b0;
      chk("s3_ignore_valid_sig", signature, 16'hBEEF);
      chk("s3_ignore_valid_cnt", vec_count, 0);
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;
      chk("s3_idle", busy, 0);

      // gappy in_valid, 3 vectors 1,2,3 from 1234 -> 2469, 48D0, 91A3
      seed = 16'h1234; num_vec = 16'd3; start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b0; set_r(4'hC); step();
      chk("s4_gap_sig", signature, 16'h1234);
      in_valid = 1'b1; set_r(4'h1); step();
      chk("s4_v1", signature, 16'h2469);
      in_valid = 1'b0; set_r(4'hE); step();
      chk("s4_gap_cnt", vec_count, 1);
      in_valid = 1'b1; set_r(4'h2); step();
      chk("s4_v2", signature, 16'h48D0);
      set_r(4'h3); step();
      chk("s4_v3", signature, 16'h91A3);
      set_r(4'h9);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("s4_hold_valid", sig_valid, 1);
         chk("s4_hold_sig", signature, 16'h91A3);
         chk("s4_hold_cnt", vec_count, 3);
      end
      in_valid = 1'b0; sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;
      chk("s4_idle", busy, 0);

      // reset after 3 of 8 transfers
      seed = 16'hFFFF; num_vec = 16'd8; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; set_r(4'h6);
      step(); step(); step();
      chk("s5_cnt3", vec_count, 3);
      rst_n = 1'b0;
      step();
      chk("s5_rst_in_ready", in_ready, 0);
      chk("s5_rst_busy", busy, 0);
      chk("s5_rst_sig", signature, 0);
      chk("s5_rst_cnt", vec_count, 0);
      chk("s5_rst_sig_valid", sig_valid, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      step();
      seed = 16'h0000; num_vec = 16'd1; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; set_r(4'hA);
      step();
      in_valid = 1'b0;
      chk("s5_fresh_valid", sig_valid, 1);
      chk("s5_fresh_sig", signature, 16'h000A);
      chk("s5_fresh_cnt", vec_count, 1);
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;

      // start ignored in RUN, and alongside sig_ready in DONE
      seed = 16'h0001; num_vec = 16'd2; start = 1'b1;
      step();
      seed = 16'hFFFF; num_vec = 16'd5; in_valid = 1'b1; set_r(4'h0);
      step();
      start = 1'b0;
      chk("s6_run_sig", signature, 16'h0002);
      chk("s6_run_cnt", vec_count, 1);
      chk("s6_run_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("s6_done_valid", sig_valid, 1);
      chk("s6_done_sig", signature, 16'h0004);
      seed = 16'hAAAA; num_vec = 16'd7; start = 1'b1; sig_ready = 1'b1;
      step();
      start = 1'b0; sig_ready = 1'b0;
      chk("s6_back_idle", busy, 0);
      chk("s6_no_reload_sig", signature, 16'h0004);
      chk("s6_no_reload_cnt", vec_count, 2);
      step();
      chk("s6_stay_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
